cpu_storebuffer_drain: RTL and testbench
========================================

// Module: cpu_storebuffer_drain
// PURPOSE
//  Drains committed stores from the store buffer head into the D-cache (hit) or main memory (miss, write-around).
//  Sits directly downstream of the store buffer: consumes its head entry and issues the pop once the store is globally performed.
//  Yields to the cache's fill/load traffic. Reports when all buffered stores are drained (fence/flush support).
// PARAMETERS
//  TAG_WIDTH   `PHYSICAL_ADDR_WIDTH  store address width; entries are word-aligned (bits [1:0]==0)
//  DATA_WIDTH  `WORD_WIDTH           store data width (4 byte lanes)
//  NUM_LINES   `NUM_CACHE_LINES      cache lines; line index = addr[4 +: $clog2(NUM_LINES)], word = addr[3:2]
//  CNT_WIDTH   16                    width of the saturating hit/miss performance counters
// PORTS
//  clock           in   1               system clock
//  reset           in   1               synchronous, active-low (0 = reset)
//  sb_empty        in   1               store buffer has no entries
//  sb_tag          in   TAG_WIDTH       head entry address (store buffer tag_pop)
//  sb_data         in   DATA_WIDTH      head entry data, lane-aligned
//  sb_bytes        in   4               head entry byte-enable mask (store buffer hit_bytes_pop)
//  sb_pop          out  1               1-cycle pulse: head entry performed; store buffer shifts on this edge
//  cache_busy      in   1               cache port owned by load/fill this cycle
//  cache_lookup    out  TAG_WIDTH       address presented for tag compare
//  cache_hit       in   1               combinational hit result for cache_lookup
//  cache_wr_en     out  1               cache word write strobe
//  cache_wr_addr   out  TAG_WIDTH       cache write address
//  cache_wr_data   out  DATA_WIDTH      cache write data
//  cache_wr_be     out  4               cache byte enables
//  mem_req_valid   out  1               memory write request valid
//  mem_req_ready   in   1               memory accepts request
//  mem_req_addr    out  TAG_WIDTH       memory write address
//  mem_req_data    out  DATA_WIDTH      memory write data
//  mem_req_be      out  4               memory byte enables
//  mem_ack         in   1               memory write completed
//  drained         out  1               sb_empty && state==IDLE
//  hit_count       out  CNT_WIDTH       stores retired to cache, saturating
//  miss_count      out  CNT_WIDTH       stores retired to memory, saturating
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, latched entry cleared, all strobes/valids 0, counters 0; drained follows sb_empty.
//  The head entry is latched into internal registers at IDLE->LOOKUP. It stays in the store buffer, visible to load forwarding, until sb_pop.
//  IDLE:   if !sb_empty && sb_bytes==0 -> sb_pop=1, stay IDLE (empty mask is discarded, no counter change).
//          else if !sb_empty && !cache_busy -> latch entry, go to LOOKUP. Otherwise stay.
//  LOOKUP: cache_lookup=latched addr. cache_busy -> stay. cache_hit -> WRITE_CACHE. Else -> MEM_REQ.
//  WRITE_CACHE: if cache_busy -> LOOKUP (line may have been replaced; re-check).
//          else cache_wr_en=1 with latched addr/data/be, sb_pop=1, hit_count++, -> IDLE.
//  MEM_REQ: mem_req_valid=1; addr/data/be held stable until mem_req_ready. On handshake -> MEM_WAIT. Valid never drops without ready.
//  MEM_WAIT: on mem_ack -> sb_pop=1, miss_count++, -> IDLE. A mem_ack arriving in the same cycle as the handshake is ignored; an ack is honoured only in MEM_WAIT.
//  Latency, no contention: hit store = 3 cycles (IDLE, LOOKUP, WRITE) from first non-empty cycle to sb_pop. Miss store = 3 cycles + ready wait + ack wait.
//  At most one store is in flight. sb_pop is never asserted in two consecutive cycles, except for back-to-back zero-mask discards.
//  Stores retire strictly in store-buffer order; a miss blocks later hits (no bypass).
//  Counters saturate at all-ones; no wrap.
//  A concurrent store-buffer PUSH does not affect the latched entry. The store buffer must never present a different head before sb_pop.
//  Reset mid-transaction: abandon the entry without popping. The memory side is reset in the same cycle; no ack is expected afterwards.
// STRUCTURE
//  CPU_cache_types.svh: add typedef enum logic [2:0] {SBD_IDLE, SBD_LOOKUP, SBD_WRITE_CACHE, SBD_MEM_REQ, SBD_MEM_WAIT} sb_drain_state_e.
//  Reuse existing word_t for data. Line index/word offset bit positions are defined as constants in CPU_define.vh.
//  Sub-module: MOD_saturating_counter (#WIDTH; clock, reset, inc, count), instantiated twice for hit/miss counters.
// TESTING
//  1. Reset low 2 cycles with sb_empty=0 -> sb_pop=0, cache_wr_en=0, mem_req_valid=0, counters 0; drained==sb_empty.
//  2. Entry addr 0x40, data 0xDEADBEEF, be 0xF, cache_hit=1 -> cache_wr_en in cycle 3 with same addr/data/be, sb_pop same cycle, hit_count=1.
//  3. Entry addr 0x104, be 0x3, cache_hit=0, mem_req_ready after 4 cycles, mem_ack 2 cycles later -> request stable all 4 cycles, sb_pop on ack cycle, miss_count=1.
//  4. Hit path with cache_busy=1 in the WRITE_CACHE cycle -> no write, returns to LOOKUP, writes once busy clears; exactly one sb_pop.
//  5. Four queued stores (hit, miss, zero-mask, hit) -> retired in order, 3 pops counted as writes, zero-mask popped with no write, drained=1 at end.
//  6. Reset asserted in MEM_WAIT -> no sb_pop, mem_req_valid=0 next cycle, state IDLE; hit_count forced to all-ones + 1 more hit -> stays all-ones.

Source files
------------

// File: rtl/cpu_storebuffer_drain_pkg.sv
// Shared types and constants for the store-buffer drain engine.
// Entries are word addresses; the line and word offset positions describe the D-cache layout.
package cpu_storebuffer_drain_pkg;

  localparam int SBD_TAG_WIDTH  = 32;
  localparam int SBD_DATA_WIDTH = 32;
  localparam int SBD_NUM_LINES  = 64;
  localparam int SBD_CNT_WIDTH  = 16;
  localparam int SBD_BE_WIDTH   = 4;
  localparam int SBD_WORD_LSB   = 2;
  localparam int SBD_LINE_LSB   = 4;

  typedef logic [SBD_DATA_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    SBD_IDLE,
    SBD_LOOKUP,
    SBD_WRITE_CACHE,
    SBD_MEM_REQ,
    SBD_MEM_WAIT
  } sb_drain_state_e;

  // A head entry with no enabled byte lanes carries no data and can be dropped at once.
  function automatic logic sbd_is_discard(input logic [SBD_BE_WIDTH-1:0] bytes);
    return (bytes == '0);
  endfunction

endpackage

// File: rtl/cpu_storebuffer_drain_sat_counter.sv
// Saturating event counter used for the hit/miss performance statistics.
module cpu_storebuffer_drain_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Sticks at all-ones so a long run can never read back as a small value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_storebuffer_drain.sv
// Drains the store-buffer head into the D-cache on a hit or writes it around to memory on a miss.
// One store in flight at a time; the head is popped only once the store is globally performed.
module cpu_storebuffer_drain
  import cpu_storebuffer_drain_pkg::*;
#(
  parameter int TAG_WIDTH  = SBD_TAG_WIDTH,
  parameter int DATA_WIDTH = SBD_DATA_WIDTH,
  parameter int NUM_LINES  = SBD_NUM_LINES,
  parameter int CNT_WIDTH  = SBD_CNT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sb_empty,
  input  logic [TAG_WIDTH-1:0]  i_sb_tag,
  input  logic [DATA_WIDTH-1:0] i_sb_data,
  input  logic [3:0]            i_sb_bytes,
  output logic                  o_sb_pop,
  input  logic                  i_cache_busy,
  output logic [TAG_WIDTH-1:0]  o_cache_lookup,
  input  logic                  i_cache_hit,
  output logic                  o_cache_wr_en,
  output logic [TAG_WIDTH-1:0]  o_cache_wr_addr,
  output logic [DATA_WIDTH-1:0] o_cache_wr_data,
  output logic [3:0]            o_cache_wr_be,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [TAG_WIDTH-1:0]  o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_data,
  output logic [3:0]            o_mem_req_be,
  input  logic                  i_mem_ack,
  output logic                  o_drained,
  output logic [CNT_WIDTH-1:0]  o_hit_count,
  output logic [CNT_WIDTH-1:0]  o_miss_count
);

  sb_drain_state_e       r_state;
  sb_drain_state_e       w_nextState;
  logic [TAG_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_be;

  logic w_latch;
  logic w_discard;
  logic w_cacheWrite;
  logic w_missDone;
  logic w_hitRetire;
  logic w_missRetire;

  // Next-state decode; the cache write and the pops are Mealy outputs so a busy
  // cache port in the write cycle suppresses them in that same cycle.
  always_comb begin
    w_nextState  = r_state;
    w_latch      = 1'b0;
    w_discard    = 1'b0;
    w_cacheWrite = 1'b0;
    w_missDone   = 1'b0;
    unique case (r_state)
      SBD_IDLE: begin
        if (!i_sb_empty && sbd_is_discard(i_sb_bytes)) begin
          w_discard = 1'b1;
        end else if (!i_sb_empty && !i_cache_busy) begin
          w_latch     = 1'b1;
          w_nextState = SBD_LOOKUP;
        end
      end
      SBD_LOOKUP: begin
        if (!i_cache_busy) begin
          w_nextState = i_cache_hit ? SBD_WRITE_CACHE : SBD_MEM_REQ;
        end
      end
      SBD_WRITE_CACHE: begin
        if (i_cache_busy) begin
          w_nextState = SBD_LOOKUP;
        end else begin
          w_cacheWrite = 1'b1;
          w_nextState  = SBD_IDLE;
        end
      end
      SBD_MEM_REQ: begin
        if (i_mem_req_ready) begin
          w_nextState = SBD_MEM_WAIT;
        end
      end
      SBD_MEM_WAIT: begin
        if (i_mem_ack) begin
          w_missDone  = 1'b1;
          w_nextState = SBD_IDLE;
        end
      end
      default: begin
        w_nextState = SBD_IDLE;
      end
    endcase
  end

  // Reset abandons any entry in flight without popping it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= SBD_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_latch) begin
        r_addr <= i_sb_tag;
        r_data <= i_sb_data;
        r_be   <= i_sb_bytes;
      end
    end
  end

  assign w_hitRetire  = i_rst_n & w_cacheWrite;
  assign w_missRetire = i_rst_n & w_missDone;

  assign o_sb_pop        = (i_rst_n & w_discard) | w_hitRetire | w_missRetire;
  assign o_cache_lookup  = r_addr;
  assign o_cache_wr_en   = w_hitRetire;
  assign o_cache_wr_addr = r_addr;
  assign o_cache_wr_data = r_data;
  assign o_cache_wr_be   = r_be;
  assign o_mem_req_valid = i_rst_n & (r_state == SBD_MEM_REQ);
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_data  = r_data;
  assign o_mem_req_be    = r_be;
  assign o_drained       = i_sb_empty & (r_state == SBD_IDLE);

  cpu_storebuffer_drain_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_hitCounter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_hitRetire),
    .o_count (o_hit_count)
  );

  cpu_storebuffer_drain_sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_missCounter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_missRetire),
    .o_count (o_miss_count)
  );

endmodule

// File: tb/tb_cpu_storebuffer_drain.sv
// Bench for cpu_storebuffer_drain: a queue models the store buffer, a small memory model answers
// write-arounds, and a per-cycle compare process checks retirement order, pops and counters.
module tb_cpu_storebuffer_drain;

  localparam int TW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          readyDelay;
    int          ackDelay;
    bit          earlyAck;
  } store_t;

  logic          clk;
  logic          rstN;
  logic          sbEmpty;
  logic [TW-1:0] sbTag;
  logic [DW-1:0] sbData;
  logic [3:0]    sbBytes;
  logic          sbPop;
  logic          cacheBusy;
  logic [TW-1:0] cacheLookup;
  logic          cacheHit;
  logic          cacheWrEn;
  logic [TW-1:0] cacheWrAddr;
  logic [DW-1:0] cacheWrData;
  logic [3:0]    cacheWrBe;
  logic          memValid;
  logic          memReady;
  logic [TW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [3:0]    memBe;
  logic          memAck;
  logic          drained;
  logic [CW-1:0] hitCount;
  logic [CW-1:0] missCount;

  cpu_storebuffer_drain #(
    .TAG_WIDTH(TW), .DATA_WIDTH(DW), .NUM_LINES(64), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_sb_empty(sbEmpty), .i_sb_tag(sbTag), .i_sb_data(sbData), .i_sb_bytes(sbBytes),
    .o_sb_pop(sbPop),
    .i_cache_busy(cacheBusy), .o_cache_lookup(cacheLookup), .i_cache_hit(cacheHit),
    .o_cache_wr_en(cacheWrEn), .o_cache_wr_addr(cacheWrAddr), .o_cache_wr_data(cacheWrData),
    .o_cache_wr_be(cacheWrBe),
    .o_mem_req_valid(memValid), .i_mem_req_ready(memReady), .o_mem_req_addr(memAddr),
    .o_mem_req_data(memData), .o_mem_req_be(memBe), .i_mem_ack(memAck),
    .o_drained(drained), .o_hit_count(hitCount), .o_miss_count(missCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The cache contents: a fixed set of resident words.
  function automatic bit inCache(input logic [31:0] a);
    return (a == 32'h40) || (a == 32'h80) || (a == 32'h84) || (a == 32'hC0);
  endfunction

  assign cacheHit = inCache(cacheLookup);

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  int popCount = 0;
  int wrCount = 0;
  int hsCount = 0;
  int validCycles = 0;
  int lastPopCycle = 0;
  int modelHits = 0;
  int modelMisses = 0;

  store_t sbQ[$];
  store_t curHead;
  bit popPending = 0;
  bit realAck = 0;
  bit waitAck = 0;
  bit hsNext = 0;
  int vcnt = 0;
  int ackCnt = 0;

  bit          prevPop = 0;
  bit          prevValid = 0;
  bit          prevReady = 0;
  logic [31:0] prevAddr = '0;
  logic [31:0] prevData = '0;
  logic [3:0]  prevBe = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveSb();
    if (sbQ.size() == 0) begin
      sbEmpty = 1'b1;
      sbTag   = '0;
      sbData  = '0;
      sbBytes = '0;
    end else begin
      sbEmpty = 1'b0;
      sbTag   = sbQ[0].addr;
      sbData  = sbQ[0].data;
      sbBytes = sbQ[0].be;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                               input int readyDelay, input int ackDelay, input bit earlyAck);
    store_t s;
    s.addr = addr;
    s.data = data;
    s.be = be;
    s.readyDelay = readyDelay;
    s.ackDelay = ackDelay;
    s.earlyAck = earlyAck;
    sbQ.push_back(s);
    driveSb();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitPops(input int n, input int budget);
    int target;
    bit ok;
    target = popCount + n;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (popCount >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("pop_timeout", 64'd0, 64'd1);
  endtask

  // Store-buffer shift on pop plus the memory responder, both just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (popPending) begin
        popPending = 0;
        if (sbQ.size() > 0) sbQ.delete(0);
        driveSb();
      end
      memAck = 1'b0;
      memReady = 1'b0;
      realAck = 0;
      if (!rstN) begin
        waitAck = 0;
        hsNext = 0;
        vcnt = 0;
        ackCnt = 0;
      end else begin
        if (hsNext) begin
          hsNext = 0;
          waitAck = 1;
          ackCnt = 0;
          vcnt = 0;
        end
        if (waitAck) begin
          ackCnt++;
          if (sbQ.size() > 0 && ackCnt >= sbQ[0].ackDelay) begin
            memAck = 1'b1;
            realAck = 1;
            waitAck = 0;
          end
        end else if (memValid && sbQ.size() > 0) begin
          vcnt++;
          if (vcnt >= sbQ[0].readyDelay) begin
            memReady = 1'b1;
            hsNext = 1;
            if (sbQ[0].earlyAck) memAck = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare against the store-buffer-order model.
  always @(negedge clk) begin
    bit haveHead;
    bit isHit;
    bit isMiss;
    bit expPop;
    cycleCnt++;
    if (!rstN) begin
      checkOutput("reset_pop", {63'd0, sbPop}, 64'd0);
      checkOutput("reset_wr", {63'd0, cacheWrEn}, 64'd0);
      modelHits = 0;
      modelMisses = 0;
      prevPop = 0;
      prevValid = 0;
      prevReady = 0;
    end else begin
      haveHead = (sbQ.size() > 0);
      isHit = 0;
      isMiss = 0;
      expPop = 0;
      if (haveHead) begin
        curHead = sbQ[0];
        if (curHead.be == 4'h0) expPop = 1;
        else if (inCache(curHead.addr)) begin
          isHit = 1;
          expPop = cacheWrEn;
        end else begin
          isMiss = 1;
          expPop = realAck;
        end
      end
      checkOutput("sb_pop", {63'd0, sbPop}, {63'd0, expPop});
      if (cacheWrEn) begin
        checkOutput("wr_while_busy", {63'd0, cacheBusy}, 64'd0);
        checkOutput("wr_is_hit", {63'd0, isHit}, 64'd1);
        if (haveHead) begin
          checkOutput("wr_addr", {32'd0, cacheWrAddr}, {32'd0, curHead.addr});
          checkOutput("wr_data", {32'd0, cacheWrData}, {32'd0, curHead.data});
          checkOutput("wr_be", {60'd0, cacheWrBe}, {60'd0, curHead.be});
        end
      end
      if (memValid) begin
        checkOutput("mem_is_miss", {63'd0, isMiss}, 64'd1);
        if (haveHead) begin
          checkOutput("mem_addr", {32'd0, memAddr}, {32'd0, curHead.addr});
          checkOutput("mem_data", {32'd0, memData}, {32'd0, curHead.data});
          checkOutput("mem_be", {60'd0, memBe}, {60'd0, curHead.be});
        end
      end
      if (prevValid && !prevReady) begin
        checkOutput("mem_valid_held", {63'd0, memValid}, 64'd1);
        checkOutput("mem_addr_stable", {32'd0, memAddr}, {32'd0, prevAddr});
        checkOutput("mem_data_stable", {32'd0, memData}, {32'd0, prevData});
        checkOutput("mem_be_stable", {60'd0, memBe}, {60'd0, prevBe});
      end
      if (prevPop && sbPop) begin
        checkOutput("b2b_pop_discard", {63'd0, (haveHead && curHead.be == 4'h0)}, 64'd1);
      end
      checkOutput("drained", {63'd0, drained}, {63'd0, (sbQ.size() == 0)});
      checkOutput("hit_count", {60'd0, hitCount}, 64'(modelHits));
      checkOutput("miss_count", {60'd0, missCount}, 64'(modelMisses));

      if (sbPop) begin
        popCount++;
        lastPopCycle = cycleCnt;
        popPending = 1;
        if (isHit && modelHits != int'(CNT_MAX)) modelHits++;
        if (isMiss && modelMisses != int'(CNT_MAX)) modelMisses++;
      end
      if (cacheWrEn) wrCount++;
      if (memValid) validCycles++;
      if (memValid && memReady) hsCount++;
      prevPop = sbPop;
      prevValid = memValid;
      prevReady = memReady;
      prevAddr = memAddr;
      prevData = memData;
      prevBe = memBe;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int p0;
    int w0;
    int h0;
    int v0;
    bit ok;

    rstN = 1'b0;
    cacheBusy = 1'b0;
    memReady = 1'b0;
    memAck = 1'b0;
    sbEmpty = 1'b1;
    sbTag = '0;
    sbData = '0;
    sbBytes = '0;

    // Reset held with a non-empty (zero-mask) head.
    applyStimulus(32'h10, 32'h0, 4'h0, 1, 1, 0);
    waitCycles(2);
    checkOutput("t1_pop", {63'd0, sbPop}, 64'd0);
    checkOutput("t1_wr", {63'd0, cacheWrEn}, 64'd0);
    checkOutput("t1_valid", {63'd0, memValid}, 64'd0);
    checkOutput("t1_hits", {60'd0, hitCount}, 64'd0);
    checkOutput("t1_misses", {60'd0, missCount}, 64'd0);
    checkOutput("t1_drained", {63'd0, drained}, 64'd0);
    rstN = 1'b1;
    waitPops(1, 10);
    checkOutput("t1_drained_after", {63'd0, drained}, 64'd1);

    // Hit store: pop in the third cycle.
    base = cycleCnt;
    applyStimulus(32'h40, 32'hDEADBEEF, 4'hF, 1, 1, 0);
    waitPops(1, 20);
    checkOutput("t2_latency", 64'(lastPopCycle - base), 64'd3);
    checkOutput("t2_hits", {60'd0, hitCount}, 64'd1);

    // Miss store with slow ready and ack.
    base = cycleCnt;
    v0 = validCycles;
    applyStimulus(32'h104, 32'hCAFEF00D, 4'h3, 4, 2, 0);
    waitPops(1, 40);
    checkOutput("t3_latency", 64'(lastPopCycle - base), 64'd8);
    checkOutput("t3_valid_cycles", 64'(validCycles - v0), 64'd4);
    checkOutput("t3_misses", {60'd0, missCount}, 64'd1);

    // Cache busy in the write cycle forces a re-lookup.
    base = cycleCnt;
    p0 = popCount;
    w0 = wrCount;
    applyStimulus(32'hC0, 32'h0BADCAFE, 4'h6, 1, 1, 0);
    waitCycles(2);
    cacheBusy = 1'b1;
    waitCycles(1);
    cacheBusy = 1'b0;
    waitPops(1, 20);
    checkOutput("t4_latency", 64'(lastPopCycle - base), 64'd5);
    checkOutput("t4_pops", 64'(popCount - p0), 64'd1);
    checkOutput("t4_writes", 64'(wrCount - w0), 64'd1);

    // Four queued stores, including an ack that coincides with the handshake.
    p0 = popCount;
    w0 = wrCount;
    h0 = hsCount;
    applyStimulus(32'h80, 32'h11111111, 4'hF, 1, 1, 0);
    applyStimulus(32'h300, 32'h22222222, 4'hC, 2, 3, 1);
    applyStimulus(32'h44, 32'h33333333, 4'h0, 1, 1, 0);
    applyStimulus(32'h84, 32'h44444444, 4'h5, 1, 1, 0);
    waitPops(4, 100);
    checkOutput("t5_pops", 64'(popCount - p0), 64'd4);
    checkOutput("t5_writes", 64'(wrCount - w0), 64'd2);
    checkOutput("t5_mem_reqs", 64'(hsCount - h0), 64'd1);
    checkOutput("t5_hits", {60'd0, hitCount}, 64'd4);
    checkOutput("t5_misses", {60'd0, missCount}, 64'd2);
    checkOutput("t5_drained", {63'd0, drained}, 64'd1);

    // Reset while waiting for the memory ack.
    h0 = hsCount;
    p0 = popCount;
    applyStimulus(32'h500, 32'h55555555, 4'hF, 1, 50, 0);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      waitCycles(1);
      if (hsCount > h0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("t6_handshake_timeout", 64'd0, 64'd1);
    waitCycles(1);
    rstN = 1'b0;
    sbQ.delete();
    popPending = 0;
    driveSb();
    waitCycles(1);
    checkOutput("t6_valid", {63'd0, memValid}, 64'd0);
    checkOutput("t6_drained", {63'd0, drained}, 64'd1);
    checkOutput("t6_hits", {60'd0, hitCount}, 64'd0);
    rstN = 1'b1;
    waitCycles(3);
    checkOutput("t6_no_pop", 64'(popCount - p0), 64'd0);
    checkOutput("t6_valid_after", {63'd0, memValid}, 64'd0);

    // Hit counter saturation.
    for (int i = 0; i < 16; i++) applyStimulus(32'h40, 32'(i), 4'hF, 1, 1, 0);
    waitPops(16, 200);
    checkOutput("t6_sat_hits", {60'd0, hitCount}, 64'd15);
    applyStimulus(32'h40, 32'h77777777, 4'hF, 1, 1, 0);
    waitPops(1, 20);
    checkOutput("t6_sat_hold", {60'd0, hitCount}, 64'd15);
    checkOutput("t6_sat_misses", {60'd0, missCount}, 64'd0);

    waitCycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
